bloco_operativo: RTL and testbench

- Datapath (operative block) that executes the control words issued by the team's FSM controller (mux selects m0/m1/m2, register enables Reg_X/Reg_H/Reg_S, mode bit h, valid).
- Holds three working registers (X, H, S) and a 2-operand ALU.
- Presents the finished value through a registered output stage with a valid/ready handshake.
- Returns a ready indication to the controller.

---
 rtl/bloco_operativo.sv | 125 ++++++++++++
 tb/tb_bloco_operativo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bloco_operativo.sv
// Operative block: three working registers, a 2-operand saturating ALU and a
// registered valid/ready output stage driven by the sequencing controller.
module bloco_operativo #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic [1:0]       m0,
  input  logic [1:0]       m1,
  input  logic [1:0]       m2,
  input  logic             h,
  input  logic             Reg_X,
  input  logic             Reg_H,
  input  logic             Reg_S,
  input  logic             valid,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             zero,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0]   r_x, r_h, r_s, r_result;
  logic               r_result_valid, r_ovf;
  logic [WIDTH-1:0]   w_a, w_b, w_raw, w_alu;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_ovf, w_any_load, w_publish;

  always_comb begin
    case (m0)
      2'd0:    w_a = x_in;
      2'd1:    w_a = r_x;
      2'd2:    w_a = r_h;
      default: w_a = r_s;
    endcase
    case (m1)
      2'd0:    w_b = r_x;
      2'd1:    w_b = r_h;
      2'd2:    w_b = r_s;
      default: w_b = {{(WIDTH-1){1'b0}}, 1'b1};
    endcase
  end

  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_prod = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};

  always_comb begin
    w_raw = w_a;
    w_ovf = 1'b0;
    case (m2)
      2'd0: begin
        w_raw = w_sum[WIDTH-1:0];
        w_ovf = w_sum[WIDTH];
      end
      2'd1: begin
        w_raw = w_a - w_b;
        w_ovf = (w_a < w_b);
      end
      2'd2: begin
        w_raw = w_prod[WIDTH-1:0];
        w_ovf = |w_prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        w_raw = w_a;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Subtraction underflow clamps to zero; add/mul overflow clamps to full scale.
  always_comb begin
    w_alu = w_raw;
    if (h && w_ovf)
      w_alu = (m2 == 2'd1) ? '0 : ALL_ONES;
  end

  assign w_any_load = Reg_X | Reg_H | Reg_S;
  assign ready      = !r_result_valid || result_ready;
  assign w_publish  = valid && ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_h <= '0;
      r_s <= '0;
    end else begin
      if (Reg_X) r_x <= w_alu;
      if (Reg_H) r_h <= w_alu;
      if (Reg_S) r_s <= w_alu;
    end
  end

  // Overflow set takes priority over the clear from an accepted publish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_ovf <= 1'b0;
    else if (w_any_load && w_ovf)
      r_ovf <= 1'b1;
    else if (w_publish)
      r_ovf <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else if (w_publish) begin
      r_result       <= r_s;
      r_result_valid <= 1'b1;
    end else if (r_result_valid && result_ready) begin
      r_result_valid <= 1'b0;
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign zero         = (r_s == '0);
  assign ovf          = r_ovf;

endmodule

// File: tb/tb_bloco_operativo.sv
// Randomized and directed bench for bloco_operativo against an arithmetic
// reference model of the register file, ALU and output handshake.
module tb_bloco_operativo;

  localparam int W = 16;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] x_in;
  logic [1:0]   m0, m1, m2;
  logic         h, Reg_X, Reg_H, Reg_S, valid, result_ready;
  logic         ready, result_valid, zero, ovf;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  longint mx, mh, ms, mres;
  bit     mrv, movf;

  bloco_operativo #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .x_in(x_in), .m0(m0), .m1(m1), .m2(m2),
    .h(h), .Reg_X(Reg_X), .Reg_H(Reg_H), .Reg_S(Reg_S), .valid(valid),
    .ready(ready), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .zero(zero), .ovf(ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; mh = 0; ms = 0; mres = 0; mrv = 0; movf = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".result"}, {16'b0, result}, mres[31:0]);
    chk({tag, ".rvalid"}, {31'b0, result_valid}, {31'b0, mrv});
    chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, movf});
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, ms == 0});
    chk({tag, ".ready"}, {31'b0, ready}, {31'b0, (!mrv) || result_ready});
  endtask

  // Called just after a falling edge; drives one control word across one rising edge.
  task automatic step(input string tag, input longint xv, input int a_sel, input int b_sel,
                      input int op, input bit hv, input bit lx, input bit lh, input bit ls,
                      input bit vv, input bit rr);
    longint a, b, ex, val;
    bit     of, rdy;
    x_in = xv[W-1:0]; m0 = a_sel[1:0]; m1 = b_sel[1:0]; m2 = op[1:0];
    h = hv; Reg_X = lx; Reg_H = lh; Reg_S = ls; valid = vv; result_ready = rr;
    a = (a_sel == 0) ? xv : (a_sel == 1) ? mx : (a_sel == 2) ? mh : ms;
    b = (b_sel == 0) ? mx : (b_sel == 1) ? mh : (b_sel == 2) ? ms : 1;
    case (op)
      0:       begin ex = a + b; of = ex > MAXV; val = ex % (MAXV + 1); end
      1:       begin of = a < b; val = (a - b + MAXV + 1) % (MAXV + 1); end
      2:       begin ex = a * b; of = ex > MAXV; val = ex % (MAXV + 1); end
      default: begin of = 0; val = a; end
    endcase
    if (hv && of) val = (op == 1) ? 0 : MAXV;
    rdy = !mrv || rr;
    if (vv && rdy) begin mres = ms; mrv = 1; end
    else if (mrv && rr) mrv = 0;
    if ((lx || lh || ls) && of) movf = 1;
    else if (vv && rdy) movf = 0;
    if (lx) mx = val;
    if (lh) mh = val;
    if (ls) ms = val;
    @(posedge clock);
    #1;
    check_all(tag);
    @(negedge clock);
  endtask

  task automatic idle(input string tag, input bit rr);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, rr);
  endtask

  initial begin
    x_in = 0; m0 = 0; m1 = 0; m2 = 0; h = 0;
    Reg_X = 0; Reg_H = 0; Reg_S = 0; valid = 0; result_ready = 0;
    reset = 1;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 5; i++) idle("idle", 0);

    // x=5: X=x, H=X*X, S=H+1, publish
    step("ldx", 5, 0, 0, 3, 0, 1, 0, 0, 0, 1);
    step("mul", 5, 1, 0, 2, 0, 0, 1, 0, 0, 1);
    step("inc", 5, 2, 3, 0, 0, 0, 0, 1, 0, 1);
    step("pub", 5, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("pub26", {16'b0, result}, 26);
    chk("pub26.v", {31'b0, result_valid}, 1);
    idle("drain", 1);
    chk("drain.v", {31'b0, result_valid}, 0);

    // saturation
    step("ldff", 'hFFFF, 0, 0, 3, 0, 1, 0, 0, 0, 1);
    step("sat_add", 0, 1, 3, 0, 1, 0, 0, 1, 0, 1);
    chk("sat_add.ovf", {31'b0, ovf}, 1);
    step("pubff", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("pubff.res", {16'b0, result}, 'hFFFF);
    step("wrap_add", 0, 1, 3, 0, 0, 0, 0, 1, 0, 1);
    chk("wrap.zero", {31'b0, zero}, 1);
    chk("wrap.ovf", {31'b0, ovf}, 1);
    step("sat_sub", 0, 3, 3, 1, 1, 0, 0, 1, 0, 1);
    chk("sat_sub.zero", {31'b0, zero}, 1);

    // backpressure
    step("ld26", 26, 0, 0, 3, 0, 0, 0, 1, 0, 0);
    step("bp_pub", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("bp.ready", {31'b0, ready}, 0);
    step("ld7", 7, 0, 0, 3, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("bp_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("bp_hold.res", {16'b0, result}, 26);
    step("bp_acc", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("bp_acc.res", {16'b0, result}, 7);
    chk("bp_acc.v", {31'b0, result_valid}, 1);
    idle("bp_drain", 1);

    // asynchronous reset mid-cycle during a multiply
    step("ar_pub", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    x_in = 3; m0 = 1; m1 = 2; m2 = 2; Reg_H = 1; valid = 0; result_ready = 0;
    #2 reset = 1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clock);
    reset = 0;
    Reg_H = 0;
    step("ar_ld9", 9, 0, 0, 3, 0, 0, 0, 1, 0, 1);
    step("ar_pub9", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("ar_pub9.res", {16'b0, result}, 9);

    // self-referencing write with simultaneous publish
    step("ld3", 3, 0, 0, 3, 0, 0, 0, 1, 0, 1);
    step("ss", 0, 3, 2, 0, 0, 0, 0, 1, 1, 1);
    chk("ss.res", {16'b0, result}, 3);
    step("ss_pub", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("ss_pub.res", {16'b0, result}, 6);

    for (int i = 0; i < 500; i++) begin
      longint xr;
      xr = (i % 7 == 0) ? MAXV - $urandom_range(0, 3) : longint'($urandom_range(0, 65535));
      step("rnd", xr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
